// File: rtl/pll_div_cntr_multi.sv
// pll_div_cntr_multi: multi-channel programmable clock divider for the
// simulation PLL model. Each channel divides clk by high+low counts, with a
// start-up phase delay and a bypass mode. New per-channel settings arrive over
// a valid/ready port, wait in a one-deep pending slot, and are applied only at
// a period boundary, on an enable drop, or while the channel is idle or
// bypassed, so a running output never glitches.
//
// Optional checks: define PLL_DIV_XCHECK_EN to add simulation-only X/Z and
// out-of-range channel warnings. Config writes carrying X/Z are then dropped.
//
// Ports:
//   clk        divider input clock (rising edge)
//   reset_n    asynchronous active-low reset
//   en         global run enable
//   cfg_valid  config request
//   cfg_ready  config accept; depends combinationally on cfg_ch
//   cfg_ch     target channel (writes to channels >= NUM_CH are dropped)
//   cfg_high   high-phase length in cycles (0 behaves as 1)
//   cfg_low    low-phase length in cycles (0 behaves as 1)
//   cfg_phase  cycles from run start to the first high phase
//   cfg_bypass channel output forced high while enabled
//   cout       registered divided clocks, one per channel
//   tick       one-cycle pulse on the first cycle of each high phase
module pll_div_cntr_multi #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_bypass,
  output logic [NUM_CH-1:0] cout,
  output logic [NUM_CH-1:0] tick
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_e;

  typedef struct packed {
    logic             bypass;
    logic [CNT_W-1:0] phase;
    logic [CNT_W-1:0] low;
    logic [CNT_W-1:0] high;
  } cfg_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam cfg_t CFG_RST = '{bypass: 1'b0, phase: '0, low: CNT_ONE, high: CNT_ONE};

  logic              ch_ok_c;
  logic              cfg_x_c;
  logic              cfg_acc_c;
  logic [NUM_CH-1:0] pending_vec;
  cfg_t              cfg_in_c;

  // Channel select in range; out-of-range writes are accepted and discarded
  assign ch_ok_c   = (32'(cfg_ch) < NUM_CH);
  assign cfg_ready = ch_ok_c ? ~pending_vec[cfg_ch] : 1'b1;
  assign cfg_acc_c = cfg_valid && cfg_ready && ch_ok_c && !cfg_x_c;
  assign cfg_in_c  = '{bypass: cfg_bypass, phase: cfg_phase, low: cfg_low, high: cfg_high};

`ifdef PLL_DIV_XCHECK_EN
  // Unknown enable or request fields poison that edge's config write
  assign cfg_x_c = $isunknown(en) ||
                   ((cfg_valid !== 1'b0) &&
                    $isunknown({cfg_valid, cfg_ch, cfg_high, cfg_low, cfg_phase, cfg_bypass}));

  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      if (cfg_x_c)
        $display("Warning : Invalid X on pll_div_cntr_multi input at time %0t in %m", $time);
      if ((cfg_valid === 1'b1) && !ch_ok_c)
        $display("Warning : pll_div_cntr_multi cfg_ch %0d out of range at time %0t in %m",
                 cfg_ch, $time);
    end
  end
`else
  assign cfg_x_c = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_max_c, low_max_c;
    cfg_t             act_q, act_d;
    cfg_t             pend_q, pend_d;
    logic             pending_q, pending_d;
    logic             cout_q, cout_d;
    logic             tick_q, tick_d;
    logic             acc_c, boundary_c, apply_c;
    logic             eff_bypass_c;
    logic [CNT_W-1:0] eff_phase_c;

    assign acc_c        = cfg_acc_c && (32'(cfg_ch) == 32'(g));
    assign high_max_c   = (act_q.high == '0) ? CNT_ONE : act_q.high;
    assign low_max_c    = (act_q.low  == '0) ? CNT_ONE : act_q.low;
    assign boundary_c   = (state_q == LOW) && (cnt_q == low_max_c);
    // Pending settings take effect where they cannot cut a running period
    assign apply_c      = pending_q && (!en || (state_q == IDLE) || act_q.bypass || boundary_c);
    // Settings governing this edge's start/restart decision
    assign eff_bypass_c = apply_c ? pend_q.bypass : act_q.bypass;
    assign eff_phase_c  = apply_c ? pend_q.phase  : act_q.phase;

    // Next-state, counter and output decode; a bypassed channel parks in IDLE
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_d     = act_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      cout_d    = 1'b0;
      tick_d    = 1'b0;

      if (apply_c) begin
        act_d     = pend_q;
        pending_d = 1'b0;
      end
      if (acc_c) begin
        pend_d    = cfg_in_c;
        pending_d = 1'b1;
      end

      if (!en) begin
        state_d = IDLE;
        cnt_d   = CNT_ONE;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_d = CNT_ONE;
            if (eff_bypass_c) begin
              cout_d = 1'b1;
              tick_d = 1'b1;
            end else if (eff_phase_c == '0) begin
              state_d = HIGH;
              cout_d  = 1'b1;
              tick_d  = 1'b1;
            end else begin
              state_d = DELAY;
            end
          end
          DELAY: begin
            if (cnt_q == act_q.phase) begin
              state_d = HIGH;
              cnt_d   = CNT_ONE;
              cout_d  = 1'b1;
              tick_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          HIGH: begin
            if (cnt_q == high_max_c) begin
              state_d = LOW;
              cnt_d   = CNT_ONE;
            end else begin
              cnt_d  = cnt_q + CNT_ONE;
              cout_d = 1'b1;
            end
          end
          LOW: begin
            if (boundary_c) begin
              state_d = eff_bypass_c ? IDLE : HIGH;
              cnt_d   = CNT_ONE;
              cout_d  = 1'b1;
              tick_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = CNT_ONE;
          end
        endcase
      end
    end

    // Channel state register
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= IDLE;
        cnt_q     <= CNT_ONE;
        act_q     <= CFG_RST;
        pend_q    <= '0;
        pending_q <= 1'b0;
        cout_q    <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        act_q     <= act_d;
        pend_q    <= pend_d;
        pending_q <= pending_d;
        cout_q    <= cout_d;
        tick_q    <= tick_d;
      end
    end

    assign cout[g]        = cout_q;
    assign tick[g]        = tick_q;
    assign pending_vec[g] = pending_q;
  end

endmodule

// File: tb/tb_pll_div_cntr_multi.sv
// Self-checking bench for pll_div_cntr_multi. The reference model tracks each
// channel as stopped / delaying / running with a position inside the period.
module tb_pll_div_cntr_multi;
  localparam int NCH = 4;

  logic       clk = 1'b0;
  logic       reset_n, en, cfg_valid, cfg_ready, cfg_bypass;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_high, cfg_low, cfg_phase;
  logic [3:0] cout, tick;

  int n_chk = 0;
  int n_err = 0;

  pll_div_cntr_multi #(.NUM_CH(4), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_phase(cfg_phase),
    .cfg_bypass(cfg_bypass), .cout(cout), .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference model: active and pending settings, mode 0=stopped 1=delaying 2=running
  int m_ah[NCH], m_al[NCH], m_ap[NCH];
  bit m_ab[NCH];
  int m_ph[NCH], m_pl[NCH], m_pp[NCH];
  bit m_pb[NCH];
  bit m_pend[NCH];
  int m_mode[NCH], m_dly[NCH], m_pos[NCH];
  bit [NCH-1:0] m_cout, m_tick;

  function automatic int eff1(int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_ah[i] = 1; m_al[i] = 1; m_ap[i] = 0; m_ab[i] = 0;
      m_pend[i] = 0; m_mode[i] = 0; m_dly[i] = 0; m_pos[i] = 0;
    end
    m_cout = '0;
    m_tick = '0;
  endfunction

  function automatic bit m_ready(int ch);
    return (ch >= NCH) ? 1'b1 : !m_pend[ch];
  endfunction

  function automatic void model_edge();
    bit acc;
    int wch;
    wch = int'(cfg_ch);
    acc = (cfg_valid === 1'b1) && (wch < NCH) && !m_pend[wch];
    for (int i = 0; i < NCH; i++) begin
      int per;
      bit bnd, app, c, t;
      per = eff1(m_ah[i]) + eff1(m_al[i]);
      bnd = (m_mode[i] == 2) && (m_pos[i] + 1 == per);
      app = m_pend[i] && (!en || m_mode[i] == 0 || m_ab[i] || bnd);
      if (app) begin
        m_ah[i] = m_ph[i]; m_al[i] = m_pl[i]; m_ap[i] = m_pp[i]; m_ab[i] = m_pb[i];
        m_pend[i] = 0;
      end
      c = 0;
      t = 0;
      if (!en) begin
        m_mode[i] = 0;
      end else if (m_mode[i] == 0) begin
        if (m_ab[i]) begin c = 1; t = 1; end
        else if (m_ap[i] == 0) begin m_mode[i] = 2; m_pos[i] = 0; end
        else begin m_mode[i] = 1; m_dly[i] = m_ap[i]; end
      end else if (m_mode[i] == 1) begin
        m_dly[i]--;
        if (m_dly[i] == 0) begin m_mode[i] = 2; m_pos[i] = 0; end
      end else begin
        if (!bnd) m_pos[i]++;
        else if (m_ab[i]) begin m_mode[i] = 0; c = 1; t = 1; end
        else m_pos[i] = 0;
      end
      if (m_mode[i] == 2) begin
        c = (m_pos[i] < eff1(m_ah[i]));
        t = (m_pos[i] == 0);
      end
      m_cout[i] = c;
      m_tick[i] = t;
      if (acc && wch == i) begin
        m_ph[i] = int'(cfg_high); m_pl[i] = int'(cfg_low);
        m_pp[i] = int'(cfg_phase); m_pb[i] = cfg_bypass;
        m_pend[i] = 1;
      end
    end
  endfunction

  // One clock: model follows the edge, outputs observed at the falling edge
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input int ch, input int h, input int l, input int p, input bit b);
    cfg_valid  = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_high   = 8'(h);
    cfg_low    = 8'(l);
    cfg_phase  = 8'(p);
    cfg_bypass = b;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_high = '0; cfg_low = '0; cfg_phase = '0; cfg_bypass = 1'b0;
    model_reset();
    #2;
    n_chk++;
    if (cout !== 4'h0 || tick !== 4'h0) begin
      n_err++;
      $display("FAIL reset_out: cout=%b tick=%b expected 0000/0000", cout, tick);
    end
    for (int ch = 0; ch < NCH; ch++) begin
      cfg_ch = 2'(ch);
      #1;
      n_chk++;
      if (cfg_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_ready ch%0d: cfg_ready=%b expected 1", ch, cfg_ready);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    cfg_ch  = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_chk++;
      if (cout !== m_cout || tick !== m_tick) begin
        n_err++;
        $display("FAIL reset_idle: cout=%b tick=%b expected %b/%b", cout, tick, m_cout, m_tick);
      end
    end
  endtask

  task automatic test_default_div2();
    logic [3:0] exp;
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k % 2 == 1) ? 4'hF : 4'h0;
      n_chk++;
      if (cout !== exp || tick !== exp || cout !== m_cout || tick !== m_tick) begin
        n_err++;
        $display("FAIL default_div2 k=%0d: cout=%b tick=%b expected %b/%b", k, cout, tick, exp, exp);
      end
    end
    n_chk++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL default_ready: cfg_ready=%b expected 1", cfg_ready);
    end
  endtask

  task automatic test_ch1_cfg();
    bit ec, et;
    en = 1'b0;
    step();
    wr(1, 3, 2, 0, 0);
    step();
    en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      ec = ((k - 1) % 5) < 3;
      et = ((k - 1) % 5) == 0;
      n_chk++;
      if (cout[1] !== ec || tick[1] !== et || cout !== m_cout || tick !== m_tick) begin
        n_err++;
        $display("FAIL ch1_3h2l k=%0d: cout=%b tick=%b expected ch1 %b/%b model %b/%b",
                 k, cout, tick, ec, et, m_cout, m_tick);
      end
    end
  endtask

  task automatic test_midperiod_update();
    bit exp2[9] = '{1, 0, 0, 1, 0, 0, 0, 0, 1};
    en = 1'b0;
    step();
    wr(2, 2, 2, 0, 0);
    step();
    en = 1'b1;
    step();
    n_chk++;
    if (cout[2] !== 1'b1 || tick[2] !== 1'b1) begin
      n_err++;
      $display("FAIL ch2_start: cout2=%b tick2=%b expected 1/1", cout[2], tick[2]);
    end
    wr(2, 1, 4, 0, 0);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      n_chk++;
      if (cout[2] !== exp2[k] || cout !== m_cout || tick !== m_tick) begin
        n_err++;
        $display("FAIL ch2_update k=%0d: cout=%b tick=%b expected ch2 %b model %b/%b",
                 k, cout, tick, exp2[k], m_cout, m_tick);
      end
      n_chk++;
      if (cfg_ready !== (k >= 3) || cfg_ready !== m_ready(2)) begin
        n_err++;
        $display("FAIL ch2_ready k=%0d: cfg_ready=%b expected %b", k, cfg_ready, (k >= 3));
      end
    end
  endtask

  task automatic test_phase();
    int rise;
    en = 1'b0;
    step();
    wr(3, 1, 1, 5, 0);
    step();
    for (int pass = 0; pass < 2; pass++) begin
      en   = 1'b1;
      rise = 0;
      for (int k = 1; k <= 20 && rise == 0; k++) begin
        step();
        if (cout[3] === 1'b1) rise = k;
        n_chk++;
        if (cout !== m_cout || tick !== m_tick) begin
          n_err++;
          $display("FAIL phase_model k=%0d: cout=%b tick=%b expected %b/%b", k, cout, tick, m_cout, m_tick);
        end
      end
      n_chk++;
      if (rise != 6) begin
        n_err++;
        $display("FAIL phase_rise pass%0d: first rise at edge %0d expected 6", pass, rise);
      end
      step();
      step();
      en = 1'b0;
      step();
      n_chk++;
      if (cout[3] !== 1'b0 || tick[3] !== 1'b0 || cout !== m_cout) begin
        n_err++;
        $display("FAIL phase_abort: cout=%b tick=%b expected ch3 0/0 model %b", cout, tick, m_cout);
      end
    end
  endtask

  task automatic test_bypass();
    bit e1;
    en = 1'b0;
    step();
    wr(0, 1, 1, 0, 1);
    wr(1, 0, 0, 0, 0);
    step();
    en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      e1 = (k % 2 == 1);
      n_chk++;
      if (cout[0] !== 1'b1 || tick[0] !== 1'b1 || cout[1] !== e1 || tick[1] !== e1 ||
          cout !== m_cout || tick !== m_tick) begin
        n_err++;
        $display("FAIL bypass k=%0d: cout=%b tick=%b expected ch0 1/1 ch1 %b model %b/%b",
                 k, cout, tick, e1, m_cout, m_tick);
      end
    end
  endtask

  task automatic test_reset_midop();
    bit in_low;
    wr(2, 3, 3, 0, 0);
    in_low = 1'b0;
    for (int k = 0; k < 10 && !in_low; k++) begin
      in_low = (m_mode[2] == 2) && (m_pos[2] >= eff1(m_ah[2]));
      if (!in_low) step();
    end
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (cout !== 4'h0 || tick !== 4'h0) begin
      n_err++;
      $display("FAIL async_reset: cout=%b tick=%b expected 0000/0000", cout, tick);
    end
    cfg_ch = 2'd2;
    #1;
    n_chk++;
    if (cfg_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pending_clr: cfg_ready=%b expected 1", cfg_ready);
    end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      n_chk++;
      if (cout !== ((k % 2 == 1) ? 4'hF : 4'h0) || cout !== m_cout || tick !== m_tick) begin
        n_err++;
        $display("FAIL post_reset_div2 k=%0d: cout=%b tick=%b expected %b/%b", k, cout, tick, m_cout, m_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en         = ($urandom_range(0, 19) != 0);
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_ch     = 2'($urandom_range(0, 3));
      cfg_high   = 8'($urandom_range(0, 4));
      cfg_low    = 8'($urandom_range(0, 4));
      cfg_phase  = 8'($urandom_range(0, 4));
      cfg_bypass = ($urandom_range(0, 7) == 0);
      #1;
      n_chk++;
      if (cfg_ready !== m_ready(int'(cfg_ch))) begin
        n_err++;
        $display("FAIL rand_ready k=%0d ch%0d: cfg_ready=%b expected %b", k, cfg_ch, cfg_ready, m_ready(int'(cfg_ch)));
      end
      step();
      n_chk++;
      if (cout !== m_cout || tick !== m_tick) begin
        n_err++;
        $display("FAIL rand_out k=%0d: cout=%b tick=%b expected %b/%b", k, cout, tick, m_cout, m_tick);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_default_div2();
    test_ch1_cfg();
    test_midperiod_update();
    test_phase();
    test_bypass();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
